// File: rtl/load_mul_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// load_mul_scoreboard_pkg
// Shared core constants for the issue-stage hazard logic: RV32 opcodes that
// matter for register-use decode, the M-extension funct7 value, and helpers
// that slice the register and opcode fields out of a 32-bit instruction.
// ----------------------------------------------------------------------------
package load_mul_scoreboard_pkg;

   localparam logic [6:0] OP_ALU        = 7'b0110011;
   localparam logic [6:0] OP_ALUI       = 7'b0010011;
   localparam logic [6:0] OP_STORE      = 7'b0100011;
   localparam logic [6:0] OP_BRANCH     = 7'b1100011;
   localparam logic [6:0] OP_LOAD       = 7'b0000011;
   localparam logic [6:0] OP_JALR       = 7'b1100111;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef logic [4:0] reg_idx_t;

   function automatic logic [6:0] opcode_of(input logic [31:0] instr);
      return instr[6:0];
   endfunction

   function automatic logic [6:0] funct7_of(input logic [31:0] instr);
      return instr[31:25];
   endfunction

   function automatic reg_idx_t rs1_of(input logic [31:0] instr);
      return instr[19:15];
   endfunction

   function automatic reg_idx_t rs2_of(input logic [31:0] instr);
      return instr[24:20];
   endfunction

   function automatic reg_idx_t rd_of(input logic [31:0] instr);
      return instr[11:7];
   endfunction

endpackage

// File: rtl/load_mul_scoreboard_instr_reg_use_decode.sv
// ----------------------------------------------------------------------------
// instr_reg_use_decode
// Combinational register-use decode of one RV32 instruction. Shared by the
// hazard scoreboard and the forwarding unit.
//   instr_i     : instruction word
//   rs1_used_o  : rs1 is read and is not x0
//   rs2_used_o  : rs2 is read and is not x0
//   rd_load_o   : instruction is a load writing a nonzero rd
//   rd_mul_o    : instruction is a mul/div writing a nonzero rd
//   is_load_o   : instruction is a load (any rd), for the outstanding-load limit
//   rs1_o/rs2_o/rd_o : register indices
// ----------------------------------------------------------------------------
module instr_reg_use_decode
   import load_mul_scoreboard_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic        rs1_used_o,
   output logic        rs2_used_o,
   output logic        rd_load_o,
   output logic        rd_mul_o,
   output logic        is_load_o,
   output reg_idx_t    rs1_o,
   output reg_idx_t    rs2_o,
   output reg_idx_t    rd_o
);

   logic [6:0] opcode;
   logic       uses_rs1;
   logic       uses_rs2;
   logic       is_mul;

   // funct3 plays no part in register-use decode
   logic unused_funct3;
   assign unused_funct3 = ^instr_i[14:12];

   always_comb begin
      opcode    = opcode_of(instr_i);
      rs1_o     = rs1_of(instr_i);
      rs2_o     = rs2_of(instr_i);
      rd_o      = rd_of(instr_i);
      uses_rs1  = (opcode == OP_ALU)   || (opcode == OP_ALUI)   ||
                  (opcode == OP_STORE) || (opcode == OP_BRANCH) ||
                  (opcode == OP_LOAD)  || (opcode == OP_JALR);
      uses_rs2  = (opcode == OP_ALU) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
      is_load_o = (opcode == OP_LOAD);
      is_mul    = (opcode == OP_ALU) && (funct7_of(instr_i) == FUNCT7_MULDIV);
      // x0 is hardwired: reading it never waits, writing it is never tracked
      rs1_used_o = uses_rs1 && (rs1_o != '0);
      rs2_used_o = uses_rs2 && (rs2_o != '0);
      rd_load_o  = is_load_o && (rd_o != '0);
      rd_mul_o   = is_mul && (rd_o != '0);
   end

endmodule

// File: rtl/load_mul_scoreboard.sv
// ----------------------------------------------------------------------------
// load_mul_scoreboard
// Issue-stage hazard unit. Tracks per-register in-flight results: loads stay
// pending until their writeback handshake, muls count down a fixed latency.
// Stalls issue on RAW, WAW and when the outstanding-load limit is reached.
//   clk, rst  : clock, asynchronous active-high reset
//   id_valid  : issue slot holds a real instruction
//   id_instr  : instruction in the issue slot
//   wb_valid  : load writeback this cycle
//   wb_rd     : destination of that writeback
//   stall     : hold the issue slot (combinational)
//   busy      : pending map after the last clock edge
//   loads_out : loads issued but not yet written back
//   wb_err    : sticky flag, writeback to a register with no pending load
// ----------------------------------------------------------------------------
module load_mul_scoreboard
   import load_mul_scoreboard_pkg::*;
#(
   parameter int unsigned NREGS     = 32,
   parameter int unsigned MUL_LAT   = 3,
   parameter int unsigned MAX_LOADS = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             id_valid,
   input  logic [31:0]                      id_instr,
   input  logic                             wb_valid,
   input  logic [4:0]                       wb_rd,
   output logic                             stall,
   output logic [NREGS-1:0]                 busy,
   output logic [$clog2(MAX_LOADS+1)-1:0]   loads_out,
   output logic                             wb_err
);

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam int LD_W  = $clog2(MAX_LOADS + 1);

   logic             rs1_used, rs2_used, rd_load, rd_mul, is_load;
   reg_idx_t         rs1, rs2, rd;

   logic [NREGS-1:0] ld_pend_q, ld_pend_d;
   logic [CNT_W-1:0] mul_cnt_q [NREGS];
   logic [CNT_W-1:0] mul_cnt_d [NREGS];
   logic [LD_W-1:0]  loads_out_q, loads_out_d;
   logic             wb_err_q, wb_err_d;

   logic [NREGS-1:0] pend;
   logic [NREGS-1:0] ep;
   logic             wb_hit;
   logic             raw, waw, ldfull, fire;

   instr_reg_use_decode u_decode (
      .instr_i    (id_instr),
      .rs1_used_o (rs1_used),
      .rs2_used_o (rs2_used),
      .rd_load_o  (rd_load),
      .rd_mul_o   (rd_mul),
      .is_load_o  (is_load),
      .rs1_o      (rs1),
      .rs2_o      (rs2),
      .rd_o       (rd)
   );

   assign wb_hit = wb_valid && ld_pend_q[wb_rd];

   // Effective pending: a load being written back this cycle is forwarded,
   // so its consumers see it as already available.
   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
         assign pend[gi] = ld_pend_q[gi] | (mul_cnt_q[gi] != '0);
         assign ep[gi]   = pend[gi] &
                           ~(wb_valid && (wb_rd == 5'(gi)) && ld_pend_q[gi]);
      end
   endgenerate

   always_comb begin
      raw   = (rs1_used && ep[rs1]) || (rs2_used && ep[rs2]);
      waw   = (rd_load || rd_mul) && ep[rd];
      // Only a writeback that really retires a load frees a slot; an erroneous
      // one must not let the count climb past the limit.
      ldfull = is_load && (loads_out_q == LD_W'(MAX_LOADS)) && !wb_hit;
      stall = id_valid && (raw || waw || ldfull);
      fire  = id_valid && !stall;
   end

   always_comb begin
      ld_pend_d = ld_pend_q;
      wb_err_d  = wb_err_q;
      for (int r = 0; r < NREGS; r++) begin
         mul_cnt_d[r] = (mul_cnt_q[r] != '0) ? mul_cnt_q[r] - CNT_W'(1) : mul_cnt_q[r];
      end
      if (wb_valid) begin
         if (wb_hit) ld_pend_d[wb_rd] = 1'b0;
         else        wb_err_d         = 1'b1;
      end
      // Issue updates come after the writeback clear so a same-rd set wins,
      // and after the decrement so a freshly issued mul starts at full count.
      if (fire && rd_load) ld_pend_d[rd] = 1'b1;
      if (fire && rd_mul)  mul_cnt_d[rd] = CNT_W'(MUL_LAT - 1);
      loads_out_d = loads_out_q + LD_W'(fire && rd_load) - LD_W'(wb_hit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_pend_q   <= '0;
         loads_out_q <= '0;
         wb_err_q    <= 1'b0;
      end else begin
         ld_pend_q   <= ld_pend_d;
         loads_out_q <= loads_out_d;
         wb_err_q    <= wb_err_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_mul_cnt
         always_ff @(posedge clk or posedge rst) begin
            if (rst) mul_cnt_q[gi] <= '0;
            else     mul_cnt_q[gi] <= mul_cnt_d[gi];
         end
      end
   endgenerate

   assign busy      = pend;
   assign loads_out = loads_out_q;
   assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_load_mul_scoreboard.sv
module tb_load_mul_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_instr;
   logic        wb_valid;
   logic [4:0]  wb_rd;

   logic        stall,  stall1;
   logic [31:0] busy,   busy1;
   logic [2:0]  loads_out, loads_out1;
   logic        wb_err, wb_err1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_mul_scoreboard #(.NREGS(32), .MUL_LAT(3), .MAX_LOADS(4)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall), .busy(busy),
      .loads_out(loads_out), .wb_err(wb_err)
   );

   load_mul_scoreboard #(.NREGS(32), .MUL_LAT(1), .MAX_LOADS(4)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall1), .busy(busy1),
      .loads_out(loads_out1), .wb_err(wb_err1)
   );

   function automatic logic [31:0] enc_load(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'd0, rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'd1, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic wv, input logic [4:0] wr);
      id_valid = v;
      id_instr = ins;
      wb_valid = wv;
      wb_rd    = wr;
      #1;
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_instr = '0; wb_valid = 1'b0; wb_rd = '0;
      #3;
      check_eq("rst_busy",      busy,      32'h0);
      check_eq("rst_loads_out", loads_out, 32'h0);
      check_eq("rst_wb_err",    wb_err,    32'h0);
      drive(1'b1, enc_add(5'd6, 5'd5, 5'd7), 1'b0, 5'd0);
      check_eq("rst_stall_any", stall, 32'h0);
      next(); rst = 1'b0; drive(1'b0, 32'h0, 1'b0, 5'd0);

      // Load-use: LOAD x5 then ADD x6,x5,x7
      next(); drive(1'b1, enc_load(5'd5, 5'd1), 1'b0, 5'd0);
      check_eq("lu_load_fire", stall, 32'h0);
      next(); drive(1'b1, enc_add(5'd6, 5'd5, 5'd7), 1'b0, 5'd0);
      check_eq("lu_stall_c1",   stall,     32'h1);
      check_eq("lu_busy5",      busy[5],   32'h1);
      check_eq("lu_loads_out1", loads_out, 32'h1);
      next(); drive(1'b1, enc_add(5'd6, 5'd5, 5'd7), 1'b0, 5'd0);
      check_eq("lu_stall_c2", stall, 32'h1);
      next(); drive(1'b1, enc_add(5'd6, 5'd5, 5'd7), 1'b1, 5'd5);
      check_eq("lu_bypass_fire", stall, 32'h0);
      next(); drive(1'b0, 32'h0, 1'b0, 5'd0);
      check_eq("lu_busy5_clr",  busy[5],   32'h0);
      check_eq("lu_loads_out0", loads_out, 32'h0);

      // Mul latency: MUL x3 then ADDI x4,x3
      next(); drive(1'b1, enc_mul(5'd3, 5'd1, 5'd2), 1'b0, 5'd0);
      check_eq("mul_fire",      stall,  32'h0);
      check_eq("mul_fire_lat1", stall1, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         next(); drive(1'b1, enc_addi(5'd4, 5'd3), 1'b0, 5'd0);
         check_eq($sformatf("mul_raw_k%0d", k), stall, (k < 3) ? 32'h1 : 32'h0);
         check_eq($sformatf("mul_raw_lat1_k%0d", k), stall1, 32'h0);
      end
      next(); drive(1'b0, 32'h0, 1'b0, 5'd0);

      // Outstanding-load limit
      for (int i = 1; i <= 4; i++) begin
         next(); drive(1'b1, enc_load(5'(i), 5'd0), 1'b0, 5'd0);
         check_eq($sformatf("ld_fill_x%0d", i), stall, 32'h0);
      end
      next(); drive(1'b1, enc_load(5'd8, 5'd0), 1'b0, 5'd0);
      check_eq("ld_full_stall", stall,     32'h1);
      check_eq("ld_full_count", loads_out, 32'h4);
      drive(1'b1, enc_load(5'd8, 5'd0), 1'b1, 5'd2);
      check_eq("ld_full_wb_fire", stall, 32'h0);
      next(); drive(1'b0, 32'h0, 1'b0, 5'd0);
      check_eq("ld_full_count_kept", loads_out, 32'h4);
      check_eq("ld_full_busy",       busy,      32'h0000_011A);
      next(); drive(1'b0, 32'h0, 1'b1, 5'd1);
      next(); drive(1'b0, 32'h0, 1'b1, 5'd3);
      next(); drive(1'b0, 32'h0, 1'b1, 5'd4);
      next(); drive(1'b0, 32'h0, 1'b1, 5'd8);
      next(); drive(1'b0, 32'h0, 1'b0, 5'd0);
      check_eq("ld_drain_count", loads_out, 32'h0);
      check_eq("ld_drain_busy",  busy,      32'h0);
      check_eq("ld_drain_err",   wb_err,    32'h0);

      // WAW: LOAD x9 pending, then MUL x9
      next(); drive(1'b1, enc_load(5'd9, 5'd0), 1'b0, 5'd0);
      next(); drive(1'b1, enc_mul(5'd9, 5'd1, 5'd2), 1'b0, 5'd0);
      check_eq("waw_stall_c1", stall, 32'h1);
      next(); drive(1'b1, enc_mul(5'd9, 5'd1, 5'd2), 1'b0, 5'd0);
      check_eq("waw_stall_c2", stall, 32'h1);
      next(); drive(1'b1, enc_mul(5'd9, 5'd1, 5'd2), 1'b1, 5'd9);
      check_eq("waw_wb_fire", stall, 32'h0);
      next(); drive(1'b0, 32'h0, 1'b0, 5'd0);
      check_eq("waw_busy9_cnt2",  busy[9],   32'h1);
      check_eq("waw_busy9_lat1",  busy1[9],  32'h0);
      check_eq("waw_loads_out",   loads_out, 32'h0);
      next();
      check_eq("waw_busy9_cnt1", busy[9], 32'h1);
      next();
      check_eq("waw_busy9_done", busy[9], 32'h0);

      // Erroneous writeback
      next(); drive(1'b1, enc_load(5'd10, 5'd0), 1'b0, 5'd0);
      next(); drive(1'b0, 32'h0, 1'b1, 5'd12);
      check_eq("err_before_edge", wb_err, 32'h0);
      next(); drive(1'b0, 32'h0, 1'b0, 5'd0);
      check_eq("err_set",        wb_err,    32'h1);
      check_eq("err_count_kept", loads_out, 32'h1);
      next(); drive(1'b0, 32'h0, 1'b1, 5'd10);
      next(); drive(1'b0, 32'h0, 1'b0, 5'd0);
      check_eq("err_sticky",    wb_err,    32'h1);
      check_eq("err_count_dec", loads_out, 32'h0);

      // x0 handling and asynchronous reset mid-stall
      next(); drive(1'b1, enc_load(5'd0, 5'd0), 1'b0, 5'd0);
      check_eq("x0_load_stall", stall, 32'h0);
      next(); drive(1'b1, enc_add(5'd1, 5'd0, 5'd0), 1'b0, 5'd0);
      check_eq("x0_add_stall", stall, 32'h0);
      check_eq("x0_busy",      busy,  32'h0);
      next(); drive(1'b1, enc_load(5'd5, 5'd0), 1'b0, 5'd0);
      next(); drive(1'b1, enc_add(5'd6, 5'd5, 5'd0), 1'b0, 5'd0);
      check_eq("arst_pre_stall", stall, 32'h1);
      rst = 1'b1;
      #1;
      check_eq("arst_stall",     stall,     32'h0);
      check_eq("arst_busy",      busy,      32'h0);
      check_eq("arst_loads_out", loads_out, 32'h0);
      check_eq("arst_wb_err",    wb_err,    32'h0);
      next(); rst = 1'b0; drive(1'b0, 32'h0, 1'b1, 5'd5);
      next(); drive(1'b0, 32'h0, 1'b0, 5'd0);
      check_eq("arst_late_wb_err", wb_err, 32'h1);
      check_eq("arst_late_count",  loads_out, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
